// File: rtl/mdu_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
// Optional MTHI/MTLO support is enabled with MDU_MTHILO_EN.
package mdu_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_PREP = 2'b01,
    ST_RUN  = 2'b10,
    ST_FIX  = 2'b11
  } mdu_state_e;

  localparam int          MDU_WIDTH   = 32;
  localparam int          MDU_ITERS   = 32;
  localparam logic [31:0] MDU_DIV0_LO = 32'hFFFF_FFFF;

endpackage

// File: rtl/mult_div_unit_mdu_step.sv
// One shift-add (multiply) or restoring-divide iteration on magnitudes.
// Purely combinational; the caller registers acc/q between steps.
module mdu_step
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic             div_mode,
  input  logic [WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0] q_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] acc_o,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shl;
  logic [WIDTH-1:0] diff;
  logic             fits;

  assign sum  = {1'b0, acc_i} + (q_i[0] ? {1'b0, b_i} : '0);
  assign shl  = {acc_i, q_i[WIDTH-1]};
  assign fits = shl >= {1'b0, b_i};
  // remainder stays below divisor, so a successful subtract fits WIDTH
  assign diff = shl[WIDTH-1:0] - b_i;

  always_comb begin
    if (div_mode) begin
      acc_o = fits ? diff : shl[WIDTH-1:0];
      q_o   = {q_i[WIDTH-2:0], fits};
    end else begin
      acc_o = sum[WIDTH:1];
      q_o   = {sum[0], q_i[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MIPS MULT/MULTU/DIV/DIVU unit holding HI/LO, 34-clock latency.
// Define MDU_MTHILO_EN to add the hilo_we/hilo_wdata MTHI/MTLO write port.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
`ifdef MDU_MTHILO_EN
  input  logic [1:0]       hilo_we,
  input  logic [WIDTH-1:0] hilo_wdata,
`endif
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  mdu_state_e       state_q, state_d;
  mdu_op_e          op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             negq_q, negq_d;
  logic             negr_q, negr_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;

  logic             is_div;
  logic             is_signed;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] step_acc;
  logic [WIDTH-1:0] step_q;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;

  assign is_div    = op_q[1];
  assign is_signed = ~op_q[0];
  assign a_neg     = is_signed & a_q[WIDTH-1];
  assign b_neg     = is_signed & b_q[WIDTH-1];
  assign a_mag     = a_neg ? -a_q : a_q;
  assign b_mag     = b_neg ? -b_q : b_q;

  assign prod      = {acc_q, q_q};
  assign prod_fix  = negq_q ? -prod : prod;
  assign quo_fix   = negq_q ? -q_q : q_q;
  assign rem_fix   = negr_q ? -acc_q : acc_q;

  // multiply and divide both iterate with q=|rs|, b=|rt|
  mdu_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .div_mode (is_div),
    .acc_i    (acc_q),
    .q_i      (q_q),
    .b_i      (b_q),
    .acc_o    (step_acc),
    .q_o      (step_q)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    dz_d    = dz_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    dbz_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          op_d    = mdu_op_e'(op);
          a_d     = rs_data;
          b_d     = rt_data;
          state_d = ST_PREP;
        end
`ifdef MDU_MTHILO_EN
        else begin
          if (hilo_we[1]) hi_d = hilo_wdata;
          if (hilo_we[0]) lo_d = hilo_wdata;
        end
`endif
      end
      ST_PREP: begin
        q_d     = a_mag;
        b_d     = b_mag;
        acc_d   = '0;
        cnt_d   = '0;
        negq_d  = a_neg ^ b_neg;
        negr_d  = a_neg & is_div;
        dz_d    = is_div & (b_q == '0);
        state_d = ST_RUN;
      end
      ST_RUN: begin
        acc_d = step_acc;
        q_d   = step_q;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) state_d = ST_FIX;
      end
      ST_FIX: begin
        done_d  = 1'b1;
        dbz_d   = dz_q;
        state_d = ST_IDLE;
        if (!is_div) begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end else if (dz_q) begin
          hi_d = a_q;
          lo_d = {WIDTH{1'b1}};
        end else begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      op_q    <= OP_MULT;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      q_q     <= '0;
      cnt_q   <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      dz_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      dz_q    <= dz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy        = (state_q != ST_IDLE);
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule
